// File: rtl/apb_logic_sequencer.sv
// apb_logic_sequencer: APB master that runs one logic-operation job on the slave.
// Each job writes op1 to 0x0, op2 to 0x4, and the opcode to 0x8 twice, then reads
// the result from 0xC. The second control write is needed because the slave
// computes its result from the register contents held before each write.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a job; req_ready high
// SETUP  | APB setup phase of the transfer selected by step
// ACCESS | APB access phase; waits for PREADY, aborts on timeout
// GAP    | one idle bus cycle between transfers (PSEL low)
// RESP   | result/error presented on the response port until rsp_ready
module apb_logic_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic [1:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] LAST_STEP = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        GAP,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      step_q, step_d;
    logic [WCW-1:0]  wait_q, wait_d;
    logic [31:0]     op1_q, op1_d;
    logic [31:0]     op2_q, op2_d;
    logic [1:0]      op_q, op_d;
    logic [31:0]     result_q, result_d;
    logic            err_q, err_d;

    // State and job registers; reset abandons any job in flight.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            step_q   <= 3'd0;
            wait_q   <= '0;
            op1_q    <= 32'd0;
            op2_q    <= 32'd0;
            op_q     <= 2'd0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            wait_q   <= wait_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: job capture, transfer sequencing, completion and timeout.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        wait_d   = wait_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        op_d     = op_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op1_d   = req_op1;
                    op2_d   = req_op2;
                    op_d    = req_op;
                    step_d  = 3'd0;
                    wait_d  = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        err_d    = 1'b1;
                        result_d = 32'd0;
                        state_d  = RESP;
                    end else if (step_q == LAST_STEP) begin
                        err_d    = 1'b0;
                        result_d = PRDATA;
                        state_d  = RESP;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = GAP;
                    end
                end else if (wait_q == WCW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th stalled cycle: give up on the job.
                    err_d    = 1'b1;
                    result_d = 32'd0;
                    state_d  = RESP;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            GAP: begin
                wait_d  = '0;
                state_d = SETUP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from state and step only; nothing from req_* or rsp_ready.
    always_comb begin
        logic xfer;
        xfer       = (state_q == SETUP) || (state_q == ACCESS);
        PSEL       = xfer;
        PENABLE    = (state_q == ACCESS);
        PADDR      = 32'd0;
        PWRITE     = 1'b0;
        PWDATA     = 32'd0;
        rsp_valid  = (state_q == RESP);
        rsp_result = result_q;
        rsp_err    = err_q;
        req_ready  = (state_q == IDLE) && !PRESET;
        if (xfer) begin
            case (step_q)
                3'd0: begin
                    PADDR  = 32'h0;
                    PWRITE = 1'b1;
                    PWDATA = op1_q;
                end
                3'd1: begin
                    PADDR  = 32'h4;
                    PWRITE = 1'b1;
                    PWDATA = op2_q;
                end
                3'd2, 3'd3: begin
                    PADDR  = 32'h8;
                    PWRITE = 1'b1;
                    PWDATA = {30'd0, op_q};
                end
                3'd4: begin
                    PADDR = 32'hC;
                end
                default: begin
                    PADDR = 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_logic_sequencer.sv
// Bench for apb_logic_sequencer: behavioural APB logic slave, directed job table,
// hand-written corner sequences and randomized jobs against a result model.
module tb_apb_logic_sequencer;

    localparam int TO = 4;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_op1, req_op2;
    logic [1:0]  req_op;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    apb_logic_sequencer #(.TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: what a job must return, straight from the opcode table.
    function automatic logic [31:0] ref_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b01:   return a & b;
            2'b10:   return a | b;
            2'b11:   return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    // Slave controls
    int          slv_wait = 1;
    bit          tie_low = 1'b0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = 32'h4;

    logic [31:0] s_op1, s_op2, s_res;
    logic [1:0]  s_ctrl;
    int          acc_n;

    assign PREADY  = PSEL && PENABLE && !tie_low && (acc_n >= slv_wait);
    assign PSLVERR = PREADY && err_en && (PADDR == err_addr);
    assign PRDATA  = (PADDR == 32'hC) ? s_res : 32'h0;

    // Bus monitor
    int          cyc = 0;
    int          psel_cnt = 0;
    logic [31:0] tr_addr[$];
    logic [31:0] tr_wdata[$];
    logic        tr_wr[$];
    int          tr_cyc[$];
    int          setup_q[$];

    // Slave register file and transfer log.
    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (PRESET) begin
            acc_n  <= 0;
            s_op1  <= 32'd0;
            s_op2  <= 32'd0;
            s_ctrl <= 2'd0;
            s_res  <= 32'd0;
        end else begin
            if (PSEL) psel_cnt <= psel_cnt + 1;
            if (PSEL && !PENABLE) setup_q.push_back(cyc);
            if (PSEL && PENABLE) begin
                if (PREADY) begin
                    acc_n <= 0;
                    tr_addr.push_back(PADDR);
                    tr_wr.push_back(PWRITE);
                    tr_wdata.push_back(PWDATA);
                    tr_cyc.push_back(cyc);
                    if (PWRITE && !PSLVERR) begin
                        s_res <= ref_fn(s_ctrl, s_op1, s_op2);
                        case (PADDR)
                            32'h0: s_op1 <= PWDATA;
                            32'h4: s_op2 <= PWDATA;
                            32'h8: s_ctrl <= PWDATA[1:0];
                            default: ;
                        endcase
                    end
                end else begin
                    acc_n <= acc_n + 1;
                end
            end else begin
                acc_n <= 0;
            end
        end
    end

    int acc_cyc;

    task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        req_op1   = a;
        req_op2   = b;
        req_op    = op;
        req_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge PCLK);
            if (req_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge PCLK);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                lat = cyc - acc_cyc;
                break;
            end
        end
    endtask

    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                           input int w, input logic [31:0] exp_res);
        int lat;
        int base;
        int sbase;
        logic [31:0] ea[5];
        logic [31:0] ed[5];
        logic        ew[5];
        ea = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC};
        ed = '{a, b, {30'd0, op}, {30'd0, op}, 32'h0};
        ew = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        slv_wait = w;
        base  = tr_addr.size();
        sbase = setup_q.size();
        start_req(a, b, op);
        wait_accept();
        wait_rsp(lat);
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_err", rsp_err, 0);
        chk("latency", lat, 5 * (w + 2) + 5);
        chk("xfer_count", tr_addr.size() - base, 5);
        for (int k = 0; k < 5; k++) begin
            if (base + k < tr_addr.size()) begin
                chk("xfer_addr", tr_addr[base + k], ea[k]);
                chk("xfer_write", tr_wr[base + k], ew[k]);
                chk("xfer_wdata", tr_wdata[base + k], ed[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (sbase + k + 1 < setup_q.size() && base + k < tr_cyc.size())
                chk("psel_gap", setup_q[sbase + k + 1] - tr_cyc[base + k], 2);
        end
        @(posedge PCLK);
        #1;
    endtask

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  op;
        int          w;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int lat;
        int base;
        int pbase;
        int cnt;
        bit found;
        logic [31:0] hr;
        logic        he;
        int rel_cyc;

        tbl[0] = '{32'hF0F0_00FF, 32'h0FF0_FF0F, 2'b01, 1, 32'h00F0_000F};
        tbl[1] = '{32'hF0F0_00FF, 32'h0FF0_FF0F, 2'b10, 1, 32'hFFF0_FFFF};
        tbl[2] = '{32'hF0F0_00FF, 32'h0FF0_FF0F, 2'b11, 1, 32'hFF00_FFF0};
        tbl[3] = '{32'h1234_5678, 32'hFFFF_0000, 2'b00, 0, 32'h0000_0000};
        tbl[4] = '{32'hAAAA_5555, 32'h0F0F_0F0F, 2'b11, 2, 32'hA5A5_5A5A};

        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_op1   = 32'd0;
        req_op2   = 32'd0;
        req_op    = 2'd0;
        rsp_ready = 1'b1;
        #2;
        chk("reset_apb_ctl", {PSEL, PENABLE, PWRITE}, 3'b000);
        chk("reset_paddr", PADDR, 0);
        chk("reset_pwdata", PWDATA, 0);
        chk("reset_rsp", {rsp_valid, rsp_err, rsp_result}, 0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        chk("ready_after_reset", req_ready, 1);
        @(posedge PCLK);
        #1;

        // Directed table: AND, OR, XOR back-to-back, op 00, extra wait state
        foreach (tbl[i]) run_job(tbl[i].op1, tbl[i].op2, tbl[i].op, tbl[i].w, tbl[i].exp);

        // Response held off for 5 cycles with a pending request behind it
        rsp_ready = 1'b0;
        slv_wait  = 1;
        start_req(32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b00);
        wait_accept();
        wait_rsp(lat);
        chk("hold_latency", lat, 20);
        chk("hold_result0", rsp_result, 0);
        hr = rsp_result;
        he = rsp_err;
        start_req(32'hF0F0_00FF, 32'h0FF0_FF0F, 2'b01);
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_stable", {rsp_err, rsp_result}, {he, hr});
            chk("hold_no_accept", req_ready, 0);
        end
        rsp_ready = 1'b1;
        rel_cyc = cyc;
        wait_accept();
        chk("accept_after_rsp", acc_cyc - rel_cyc, 1);
        wait_rsp(lat);
        chk("pending_result", rsp_result, 32'h00F0_000F);
        @(posedge PCLK);
        #1;

        // PSLVERR on the op2 write
        err_en   = 1'b1;
        err_addr = 32'h4;
        slv_wait = 1;
        base = tr_addr.size();
        start_req(32'h1111_1111, 32'h2222_2222, 2'b10);
        wait_accept();
        wait_rsp(lat);
        chk("slverr_err", rsp_err, 1);
        chk("slverr_result", rsp_result, 0);
        chk("slverr_latency", lat, 8);
        chk("slverr_xfers", tr_addr.size() - base, 2);
        if (tr_addr.size() > base + 1) chk("slverr_last_addr", tr_addr[base + 1], 32'h4);
        err_en = 1'b0;
        @(posedge PCLK);
        #1;

        // Timeout with PREADY tied low
        tie_low = 1'b1;
        base  = tr_addr.size();
        pbase = psel_cnt;
        start_req(32'h3333_3333, 32'h4444_4444, 2'b11);
        wait_accept();
        wait_rsp(lat);
        chk("timeout_err", rsp_err, 1);
        chk("timeout_result", rsp_result, 0);
        chk("timeout_latency", lat, 6);
        chk("timeout_psel_cycles", psel_cnt - pbase, TO + 1);
        chk("timeout_xfers", tr_addr.size() - base, 0);
        tie_low = 1'b0;
        @(posedge PCLK);
        #1;
        run_job(32'h3333_3333, 32'h4444_4444, 2'b11, 1, 32'h7777_7777);

        // Reset during the step-2 access
        slv_wait = 1;
        start_req(32'h5555_0000, 32'h00FF_00FF, 2'b11);
        wait_accept();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (PSEL && PENABLE && PADDR == 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_step2", found, 1);
        PRESET = 1'b1;
        #1;
        chk("midrst_apb_ctl", {PSEL, PENABLE, PWRITE}, 3'b000);
        chk("midrst_addr_data", {PADDR, PWDATA}, 0);
        chk("midrst_rsp", {rsp_valid, rsp_err, rsp_result}, 0);
        @(posedge PCLK);
        @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge PCLK);
            if (rsp_valid || PSEL) cnt++;
        end
        chk("midrst_no_response", cnt, 0);
        chk("midrst_ready", req_ready, 1);
        @(posedge PCLK);
        #1;
        run_job(32'h5555_0000, 32'h00FF_00FF, 2'b11, 1, 32'h55AA_00FF);

        // Randomized jobs against the reference result
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            logic [1:0]  op;
            int          w;
            a  = $urandom;
            b  = $urandom;
            op = 2'($urandom_range(0, 3));
            w  = $urandom_range(0, 2);
            run_job(a, b, op, w, ref_fn(op, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_logic_sequencer.md
# apb_logic_sequencer

APB master that runs complete jobs on the APB logic-operation slave. The slave has operand1 at 0x0, operand2 at 0x4, control at 0x8 and a read-only result at 0xC. Each job takes two operands and an opcode from a valid/ready request port, performs the required APB writes and the result read, and returns the result (or an error) on a valid/ready response port. It sits between a local requester and the slave's APB port, and is the only master on that bus.

## Interface
- TIMEOUT, 16: maximum ACCESS cycles with PREADY low before a transfer is aborted (≥1).
- PCLK  in  1  clock; all state on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  job request valid.
- req_ready  out  1  sequencer can accept a job.
- req_op1  in  32  operand 1.
- req_op2  in  32  operand 2.
- req_op  in  2  opcode: 01 AND, 10 OR, 11 XOR, 00 yields 0.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_result  out  32  result word read from 0xC.
- rsp_err  out  1  job aborted: PSLVERR or timeout.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR, PWDATA  out  32 each  APB address and write data.
- PRDATA  in  32  APB read data.
- PREADY, PSLVERR  in  1 each  APB completion and error.

## Operation
- States: IDLE, SETUP, ACCESS, GAP, RESP.
- A job is accepted on the edge where req_valid && req_ready. req_ready = 1 only in IDLE. req_op1, req_op2 and req_op are captured into internal registers at acceptance.
- The job is a fixed 5-step sequence held in a 3-bit step counter:
  - step 0: write 0x0 = op1
  - step 1: write 0x4 = op2
  - step 2: write 0x8 = {30'b0, op}
  - step 3: write 0x8 = {30'b0, op} again
  - step 4: read 0xC
- Step 3 is mandatory. The slave updates its result on each accepted write using the register contents from before that write, so the second control write commits the new opcode.
- IDLE → SETUP on acceptance, with step = 0.
- SETUP → ACCESS unconditionally.
  - SETUP drives PSEL=1, PENABLE=0, PADDR, PWRITE, PWDATA.
  - ACCESS holds the same values with PENABLE=1.
- ACCESS completes when PREADY = 1.
  - If PSLVERR = 1 at completion: rsp_err ← 1, rsp_result ← 0, go to RESP.
  - Otherwise, at step 4: rsp_result ← PRDATA, rsp_err ← 0, go to RESP.
  - Otherwise: step++, go to GAP.
- GAP → SETUP.
  - GAP drives PSEL=0, PENABLE=0.
  - The slave holds PREADY high until it samples PSEL low, so one idle cycle between transfers is mandatory.
- Timeout: wait_cnt counts consecutive ACCESS cycles with PREADY = 0 and clears on entry to SETUP.
  - When wait_cnt reaches TIMEOUT: drop PSEL, rsp_err ← 1, rsp_result ← 0, go to RESP.
  - The remaining steps are skipped.
- RESP: rsp_valid = 1, PSEL = 0. On rsp_ready the state goes to IDLE. rsp_result and rsp_err stay stable while rsp_valid is high.
- PWDATA = 0 and PWRITE = 0 during the read and in all non-transfer states.
- PSLVERR and PRDATA are ignored outside the completing ACCESS cycle.

## Timing
- Reset values, asserted asynchronously while PRESET is high:
  - state = IDLE, step = 0, wait_cnt = 0.
  - PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0.
  - rsp_valid = 0, rsp_result = 0, rsp_err = 0.
  - req_ready = 1 once PRESET deasserts.
- Reset mid-job abandons the job with no response and drops PSEL immediately.
- All outputs are registered or decoded from state and registers. There is no combinational path from req_* or rsp_ready to APB outputs.
- Cycle 0 is the cycle in which req_valid && req_ready. With a slave that asserts PREADY one cycle into ACCESS:
  - Transfer k occupies cycles 4k+1 (SETUP), 4k+2 (ACCESS, wait), 4k+3 (ACCESS, complete) and 4k+4 (GAP).
  - The read completes in cycle 19.
  - rsp_valid is first high in cycle 20.
- Total latency is 20 cycles. With PREADY high on the first ACCESS cycle, each transfer is one cycle shorter.
- rsp_valid && rsp_ready in cycle N gives IDLE with req_ready = 1 in cycle N+1. The earliest next acceptance is cycle N+1.
- A request held while busy is not accepted and must wait. No request is lost or duplicated.

## Test plan
- AND job: op1=0xF0F0_00FF, op2=0x0FF0_FF0F, op=01.
  - APB sequence is writes 0x0, 0x4, 0x8, 0x8, then read 0xC.
  - rsp_result=0x00F0_000F, rsp_err=0, rsp_valid in cycle 20.
- OR then XOR jobs back-to-back on the same operands:
  - OR job gives 0xFFF0_FFFF.
  - XOR job gives 0xFF00_FFF0.
  - PSEL is low for exactly one cycle between consecutive transfers.
- op=00 → rsp_result=0. Hold rsp_ready=0 for 5 cycles:
  - rsp_valid, rsp_result and rsp_err stay stable.
  - req_ready stays 0 and a pending req_valid is not accepted until the cycle after rsp_ready.
- Force PSLVERR=1 on the step-1 completion:
  - Steps 2–4 are never issued.
  - rsp_err=1, rsp_result=0.
- Tie PREADY=0 with TIMEOUT=4:
  - PSEL drops after 4 ACCESS cycles of step 0.
  - rsp_err=1.
  - The next job completes normally once PREADY is released.
- Assert PRESET during the ACCESS of step 2:
  - All outputs take their reset values immediately and no response is issued.
  - The following job returns the correct result.
